nn_layer_sequencer: RTL and testbench

//  Avalon-MM slave that sequences the accelerator's layer engines one after another.
//  It gives each layer engine a start pulse and waits for that engine's done handshake.
//  It publishes a per-layer ready vector on ready_out, which feeds the HPS-visible ready PIO.
//  HPS writes CTRL to launch a run, then polls STATUS or waits on irq.

---
 rtl/nn_seq_pkg.sv | 29 ++
 rtl/nn_seq_timeout_ctr.sv | 37 +++
 rtl/nn_layer_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_seq_pkg.sv
// Shared constants for the layer sequencer: register map, CTRL/STATUS bit
// positions and the sequencer state encoding.
package nn_seq_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
  localparam logic [1:0] ADDR_READY   = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_LAST_LSB  = 4;
  localparam int CTRL_IRQEN_BIT = 8;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_TOERR_BIT = 2;
  localparam int STAT_CUR_LSB   = 4;
  localparam int STAT_IRQ_BIT   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FINISH = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

endpackage

// File: rtl/nn_seq_timeout_ctr.sv
// Loadable down-counter that flags a per-layer wait timeout; a zero load
// value means the timeout is disabled and never expires.
module nn_seq_timeout_ctr
  import nn_seq_pkg::*;
#(
  parameter int TO_W = 24
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [TO_W-1:0] value,
  input  logic            en,
  output logic            expired
);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en & (count_q == '0) & (value != '0);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Avalon-MM slave that starts each layer engine in turn, waits for its done
// handshake (with optional timeout) and publishes per-layer completion.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 7,
  parameter int TO_W       = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] ready_out,
  output logic                  irq
);

  localparam logic [2:0] MAX_LAYER = 3'(NUM_LAYERS - 1);

  state_e                state_q, state_d;
  logic [2:0]            cur_layer_q, cur_layer_d;
  logic [2:0]            last_layer_q, last_layer_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [NUM_LAYERS-1:0] ready_q, ready_d;
  logic [TO_W-1:0]       timeout_q, timeout_d;

  logic                  wr, wr_ctrl, wr_status, wr_timeout;
  logic                  start_req, abort_req;
  logic [2:0]            wr_last;
  logic [NUM_LAYERS-1:0] cur_onehot;
  logic                  cur_done;
  logic                  timer_load, timer_en, timer_expired;
  logic                  unused_wdata;

  assign wr         = chipselect & ~write_n;
  assign wr_ctrl    = wr & (address == ADDR_CTRL);
  assign wr_status  = wr & (address == ADDR_STATUS);
  assign wr_timeout = wr & (address == ADDR_TIMEOUT);
  assign start_req  = wr_ctrl & writedata[CTRL_START_BIT];
  assign abort_req  = wr_ctrl & writedata[CTRL_ABORT_BIT];
  assign wr_last    = (writedata[CTRL_LAST_LSB +: 3] > MAX_LAYER) ? MAX_LAYER
                                                                  : writedata[CTRL_LAST_LSB +: 3];
  assign unused_wdata = ^writedata;

  // Only the engine currently being waited on can complete the layer.
  assign cur_onehot = NUM_LAYERS'(1) << cur_layer_q;
  assign cur_done   = |(layer_done & cur_onehot);

  nn_seq_timeout_ctr #(
    .TO_W (TO_W)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .value   (timeout_q),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    cur_layer_d   = cur_layer_q;
    last_layer_d  = last_layer_q;
    irq_en_d      = irq_en_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    ready_d       = ready_q;
    timeout_d     = timeout_q;
    timer_load    = 1'b0;
    timer_en      = 1'b0;

    if (wr_timeout) begin
      timeout_d = writedata[TO_W-1:0];
    end
    // W1C clears come first so a same-cycle FINISH/FAULT set overrides them.
    if (wr_status) begin
      if (writedata[STAT_DONE_BIT])  done_d        = 1'b0;
      if (writedata[STAT_TOERR_BIT]) timeout_err_d = 1'b0;
    end

    if (abort_req && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_ctrl) begin
            last_layer_d = wr_last;
            irq_en_d     = writedata[CTRL_IRQEN_BIT];
          end
          if (start_req && !abort_req) begin
            ready_d       = '0;
            done_d        = 1'b0;
            timeout_err_d = 1'b0;
            cur_layer_d   = 3'd0;
            state_d       = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_load = 1'b1;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          timer_en = 1'b1;
          if (cur_done) begin
            ready_d = ready_q | cur_onehot;
            if (cur_layer_q == last_layer_q) begin
              state_d = ST_FINISH;
            end else begin
              cur_layer_d = cur_layer_q + 3'd1;
              state_d     = ST_ISSUE;
            end
          end else if (timer_expired) begin
            state_d = ST_FAULT;
          end
        end
        ST_FINISH: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_FAULT: begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cur_layer_q   <= 3'd0;
      last_layer_q  <= 3'd0;
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      ready_q       <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      cur_layer_q   <= cur_layer_d;
      last_layer_q  <= last_layer_d;
      irq_en_q      <= irq_en_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      ready_q       <= ready_d;
      timeout_q     <= timeout_d;
    end
  end

  assign layer_start = (state_q == ST_ISSUE) ? cur_onehot : '0;
  assign ready_out   = ready_q;
  assign irq         = irq_en_q & (done_q | timeout_err_q);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_IRQEN_BIT]     = irq_en_q;
        readdata[CTRL_LAST_LSB +: 3] = last_layer_q;
      end
      ADDR_STATUS: begin
        readdata[STAT_BUSY_BIT]     = (state_q != ST_IDLE);
        readdata[STAT_DONE_BIT]     = done_q;
        readdata[STAT_TOERR_BIT]    = timeout_err_q;
        readdata[STAT_CUR_LSB +: 3] = cur_layer_q;
        readdata[STAT_IRQ_BIT]      = irq;
      end
      ADDR_TIMEOUT: readdata[TO_W-1:0]       = timeout_q;
      ADDR_READY:   readdata[NUM_LAYERS-1:0] = ready_q;
    endcase
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized bench for nn_layer_sequencer: an engine model answers each layer
// start after a chosen latency and outcomes are predicted per run.
module tb_nn_layer_sequencer;
  import nn_seq_pkg::*;

  localparam int NL = 7;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [NL-1:0] layer_start;
  logic [NL-1:0] layer_done = '0;
  logic [NL-1:0] ready_out;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;
  int lat_tab [NL];

  always #5 clk = ~clk;

  nn_layer_sequencer #(.NUM_LAYERS(NL), .TO_W(24)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .layer_start (layer_start),
    .layer_done  (layer_done),
    .ready_out   (ready_out),
    .irq         (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic present_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    layer_done = '0;
    present_write(a, d);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle_gap(input int cycles);
    logic [31:0] st;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      check_eq("idle_no_start", 32'(layer_start), 0);
      read_reg(ADDR_STATUS, st);
      check_eq("idle_busy", st & 32'h1, 0);
      layer_done = NL'($urandom);
    end
    @(negedge clk);
    layer_done = '0;
  endtask

  // One run: layer j answers lat_tab[j] cycles after its start pulse.
  // With TIMEOUT=T!=0 a layer survives only if its answer arrives within T+1 cycles.
  task automatic run_case(input int last_req, input int tmo, input bit ien, input int abort_layer,
                          input bit busy_start, input bit w1c_race, input bit noise);
    int last;
    logic [NL-1:0] exp_ready;
    logic [31:0] st;
    bit ended;
    last  = (last_req > NL - 1) ? NL - 1 : last_req;
    ended = 1'b0;
    bus_write(ADDR_TIMEOUT, 32'(tmo));
    read_reg(ADDR_TIMEOUT, st);
    check_eq("timeout_rb", st, 32'(tmo));
    bus_write(ADDR_CTRL, (32'(ien) << 8) | (32'(last_req) << 4) | 32'h1);
    exp_ready = '0;
    read_reg(ADDR_CTRL, st);
    check_eq("ctrl_rb", st, (32'(ien) << 8) | (32'(last) << 4));
    read_reg(ADDR_STATUS, st);
    check_eq("status_issue", st, 32'h1);
    for (int j = 0; j <= last && !ended; j++) begin
      int d;
      bit hit;
      bit fin;
      d   = lat_tab[j];
      hit = (tmo != 0) && (d > tmo + 1);
      fin = 1'b0;
      check_eq("start_pulse", 32'(layer_start), 32'(1) << j);
      check_eq("ready_step", 32'(ready_out), 32'(exp_ready));
      for (int n = 1; n < 4000 && !fin; n++) begin
        @(negedge clk);
        layer_done = '0; chipselect = 1'b0; write_n = 1'b1;
        if (abort_layer == j) begin
          if (n == 1) begin
            present_write(ADDR_CTRL, 32'h2);
          end else begin
            check_eq("abort_no_start", 32'(layer_start), 0);
            if (n == 2) begin
              read_reg(ADDR_STATUS, st);
              check_eq("abort_status", st & 32'h7, 0);
              check_eq("abort_ready", 32'(ready_out), 32'(exp_ready));
            end
            if (n == 6) begin fin = 1'b1; ended = 1'b1; end
          end
        end else if (hit) begin
          read_reg(ADDR_STATUS, st);
          if (n <= tmo + 1) begin
            check_eq("wait_status", st, 32'h1 | (32'(j) << 4));
            check_eq("wait_no_start", 32'(layer_start), 0);
          end else if (n == tmo + 2) begin
            check_eq("fault_state", st, 32'h1 | (32'(j) << 4));
            if (w1c_race) present_write(ADDR_STATUS, 32'h6);
          end else begin
            check_eq("fault_status", st, 32'h4 | (32'(j) << 4) | (32'(ien) << 8));
            check_eq("fault_ready", 32'(ready_out), 32'(exp_ready));
            check_eq("fault_irq", 32'(irq), 32'(ien));
            fin = 1'b1; ended = 1'b1;
          end
        end else begin
          if (n <= d) begin
            read_reg(ADDR_STATUS, st);
            check_eq("wait_status", st, 32'h1 | (32'(j) << 4));
            check_eq("wait_no_start", 32'(layer_start), 0);
          end else if (j < last) begin
            exp_ready[j] = 1'b1;
            fin = 1'b1;
          end else if (n == d + 1) begin
            exp_ready[j] = 1'b1;
            read_reg(ADDR_STATUS, st);
            check_eq("finish_state", st, 32'h1 | (32'(j) << 4));
            check_eq("finish_ready", 32'(ready_out), 32'(exp_ready));
            if (w1c_race) present_write(ADDR_STATUS, 32'h6);
          end else begin
            read_reg(ADDR_STATUS, st);
            check_eq("done_status", st, 32'h2 | (32'(j) << 4) | (32'(ien) << 8));
            check_eq("done_ready", 32'(ready_out), 32'(exp_ready));
            check_eq("done_irq", 32'(irq), 32'(ien));
            fin = 1'b1; ended = 1'b1;
          end
        end
        if (!fin) begin
          if (n == d) layer_done[j] = 1'b1;
          if (noise) layer_done = layer_done | (NL'($urandom | (32'(1) << (NL - 1))) & ~(NL'(1) << j));
          if (busy_start && j == 1 && n == 1 && abort_layer != 1) present_write(ADDR_CTRL, 32'h1);
        end
      end
    end
    read_reg(ADDR_CTRL, st);
    check_eq("ctrl_hold", st, (32'(ien) << 8) | (32'(last) << 4));
    bus_write(ADDR_STATUS, 32'h6);
    check_eq("irq_cleared", 32'(irq), 0);
    read_reg(ADDR_STATUS, st);
    check_eq("flags_cleared", st & 32'h107, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_start", 32'(layer_start), 0);
    check_eq("rst_ready", 32'(ready_out), 0);
    check_eq("rst_irq", 32'(irq), 0);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), st);
      check_eq("rst_reg", st, 0);
    end

    // Four layers, fixed 5-cycle engine latency, interrupt enabled
    for (int k = 0; k < NL; k++) lat_tab[k] = 5;
    run_case(3, 0, 1'b1, -1, 1'b0, 1'b0, 1'b0);

    // Layer 1 never answers with TIMEOUT=10
    lat_tab[0] = 3; lat_tab[1] = 1000;
    run_case(2, 10, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // last_layer 7 clamps to 6; busy start ignored; stray dones; abort in layer 4
    for (int k = 0; k < NL; k++) lat_tab[k] = 4;
    run_case(7, 0, 1'b0, 4, 1'b1, 1'b0, 1'b1);

    // Done on the expiry cycle wins; one cycle later it is a timeout
    lat_tab[0] = 5;
    run_case(0, 4, 1'b1, -1, 1'b0, 1'b1, 1'b0);
    lat_tab[0] = 6;
    run_case(0, 4, 1'b1, -1, 1'b0, 1'b1, 1'b0);

    // Start together with abort in IDLE does nothing
    bus_write(ADDR_CTRL, 32'h3);
    check_eq("startabort_no_start", 32'(layer_start), 0);
    idle_gap(3);

    // Randomized runs
    for (int r = 0; r < 16; r++) begin
      int lr, t, lastc, ab;
      lr    = $urandom_range(7, 0);
      t     = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(8, 1);
      lastc = (lr > NL - 1) ? NL - 1 : lr;
      for (int k = 0; k < NL; k++) lat_tab[k] = $urandom_range((t == 0) ? 8 : t + 2, 1);
      ab = ($urandom_range(3, 0) == 0) ? $urandom_range(lastc, 0) : -1;
      run_case(lr, t, 1'($urandom), ab, 1'($urandom), 1'($urandom), 1'($urandom));
      idle_gap(2);
    end

    // Asynchronous reset in the middle of a wait
    for (int k = 0; k < NL; k++) lat_tab[k] = 20;
    bus_write(ADDR_TIMEOUT, 32'h0);
    bus_write(ADDR_CTRL, 32'h131);
    @(negedge clk);
    @(negedge clk);
    layer_done = 7'h01;
    @(negedge clk);
    layer_done = '0;
    check_eq("pre_rst_start", 32'(layer_start), 32'h2);
    check_eq("pre_rst_ready", 32'(ready_out), 32'h1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_start", 32'(layer_start), 0);
    check_eq("async_rst_ready", 32'(ready_out), 0);
    check_eq("async_rst_irq", 32'(irq), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), st);
      check_eq("post_rst_reg", st, 0);
    end
    idle_gap(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
